trans_term_tracker: RTL and testbench
=====================================

Name: trans_term_tracker

Overview:
- Sits directly upstream of the transfer allocator's termination inputs.
- Each transfer SID is issued to the datapath as one or more chunk commands. This block counts outstanding chunks per SID.
- It emits a one-cycle term_sig pulse for a SID once its last chunk has been issued and every issued chunk has completed.
- term_sig_o connects bit-for-bit to the allocator's term_sig_i.

Parameters:
NB_TRANSFERS, 4, number of transfer SIDs tracked
TRANS_SID_WIDTH, 2, SID width; must equal clog2(NB_TRANSFERS)
CNT_WIDTH, 4, per-SID outstanding-chunk counter width; max outstanding = 2**CNT_WIDTH-1

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
cmd_req_i  in  1  chunk command request from the command queue
cmd_gnt_i  in  1  datapath grant; a chunk is issued when req&gnt
cmd_sid_i  in  TRANS_SID_WIDTH  SID of the issued chunk
cmd_last_i  in  1  issued chunk is the final chunk of its transfer
done_valid_i  in  1  one chunk completed this cycle
done_sid_i  in  TRANS_SID_WIDTH  SID of the completed chunk
term_sig_o  out  NB_TRANSFERS  one-cycle termination pulse per SID
cnt_full_o  out  NB_TRANSFERS  SID counter at max; upstream must not issue on that SID
err_o  out  1  sticky protocol-error flag
busy_o  out  NB_TRANSFERS  SID state != IDLE

Behaviour:
- Reset (rst_ni=0 at posedge): all counters 0, all SIDs IDLE, term_sig_o=0, err_o=0. cnt_full_o and busy_o are therefore 0.
- Reset mid-transfer discards all counts and suppresses any pending term pulse.
- issue[s] = cmd_req_i & cmd_gnt_i & (cmd_sid_i==s).
- comp[s] = done_valid_i & (done_sid_i==s).
- Per-SID counter update:
  - issue only: +1.
  - comp only: -1.
  - issue and comp together: unchanged.
  - No wrap in either direction.
- Per-SID FSM states: IDLE, ACTIVE, DRAIN, TERM.
- IDLE:
  - issue & !last -> ACTIVE.
  - issue & last -> DRAIN.
  - comp -> err, stay IDLE, counter unchanged.
- ACTIVE:
  - issue & last -> DRAIN.
  - Otherwise stay ACTIVE; counter may reach 0 without terminating.
- DRAIN, with cnt_next the post-update count:
  - cnt_next==0 -> TERM.
  - issue in DRAIN -> err, increment ignored.
- TERM:
  - Lasts exactly one cycle, then IDLE.
  - term_sig_o[s]=1 only while in TERM; it is a registered output.
  - issue or comp on s while in TERM -> err, ignored.
- Latency: the completion that empties a DRAIN SID at edge N gives term_sig_o high in cycle N+1, for one cycle.
- Issue of the last chunk with a same-cycle completion of the only outstanding chunk: count 1->1, state DRAIN, no term.
- Overflow: issue while count==max and no simultaneous comp -> err, increment dropped.
- Underflow: comp while count==0 in any state -> err, decrement dropped.
- cnt_full_o[s] = (count==max), combinational from the register.
- Different SIDs are fully independent. Several SIDs may pulse term_sig_o in the same cycle; the downstream allocator serializes them.
- err_o is sticky until reset. It does not affect other SIDs.

Test Plan:
- Single-chunk: issue sid=2 last=1, then done sid=2 two cycles later -> term_sig_o=4'b0100 for exactly one cycle in the cycle after the done edge; busy_o[2] low afterwards.
- Multi-chunk: sid=1 issues 3 chunks (last on the 3rd), completions interleaved (1 done between issues 2 and 3) -> no pulse until the 3rd completion; then term_sig_o[1] one cycle; err_o=0.
- Simultaneous events:
  - sid=0 with count=1: issue last + done in the same cycle -> count stays 1, no pulse; the next done gives the pulse.
  - sid=0 and sid=3 both emptied the same cycle -> term_sig_o=4'b1001.
- Overflow/underflow with CNT_WIDTH=2:
  - 3 issues on sid=0 -> cnt_full_o[0]=1.
  - A 4th issue -> err_o=1, count stays 3.
  - A separate done on IDLE sid=1 -> err_o stays 1, sid=1 stays IDLE.
- Reset mid-operation: sid=1 in DRAIN with count=2, rst_ni low one cycle -> all outputs 0 next cycle; a subsequent done sid=1 sets err_o and produces no pulse.
- Back-to-back reuse: after the TERM on sid=2, issue sid=2 last=1 on the cycle right after the pulse -> accepted cleanly (IDLE->DRAIN), err_o=0.

Source files
------------

// File: rtl/trans_term_tracker.sv
`timescale 1ns/1ps
// trans_term_tracker
// Counts outstanding chunk commands per transfer SID. Once the last chunk of
// a SID has been issued and all its chunks have completed, the SID pulses
// term_sig_o for one cycle. The pulse feeds the allocator's termination input.
//
// Ports:
//   clk_i, rst_ni    clock, synchronous active-low reset
//   cmd_req_i/gnt_i  chunk issue handshake (issue = req & gnt)
//   cmd_sid_i        SID of the issued chunk
//   cmd_last_i       issued chunk is the last one of its transfer
//   done_valid_i     one chunk completed this cycle
//   done_sid_i       SID of the completed chunk
//   term_sig_o       registered one-cycle termination pulse per SID
//   cnt_full_o       per-SID counter at max (combinational from the register)
//   err_o            sticky protocol-error flag
//   busy_o           registered, per-SID state != IDLE
module trans_term_tracker #(
    parameter int unsigned NB_TRANSFERS    = 4,
    parameter int unsigned TRANS_SID_WIDTH = 2,
    parameter int unsigned CNT_WIDTH       = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cmd_req_i,
    input  logic                       cmd_gnt_i,
    input  logic [TRANS_SID_WIDTH-1:0] cmd_sid_i,
    input  logic                       cmd_last_i,
    input  logic                       done_valid_i,
    input  logic [TRANS_SID_WIDTH-1:0] done_sid_i,
    output logic [NB_TRANSFERS-1:0]    term_sig_o,
    output logic [NB_TRANSFERS-1:0]    cnt_full_o,
    output logic                       err_o,
    output logic [NB_TRANSFERS-1:0]    busy_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2,
        S_TERM   = 2'd3
    } state_e;

    state_e                  state_q [NB_TRANSFERS];
    state_e                  state_d [NB_TRANSFERS];
    logic [CNT_WIDTH-1:0]    cnt_q   [NB_TRANSFERS];
    logic [CNT_WIDTH-1:0]    cnt_d   [NB_TRANSFERS];
    logic [NB_TRANSFERS-1:0] term_q, term_d;
    logic [NB_TRANSFERS-1:0] busy_q, busy_d;
    logic                    err_q, err_d;
    logic [NB_TRANSFERS-1:0] err_vec;
    logic [NB_TRANSFERS-1:0] issue, comp;

    // Per-SID decode of the issue and completion events
    always_comb begin
        issue = '0;
        comp  = '0;
        for (int s = 0; s < NB_TRANSFERS; s++) begin
            issue[s] = cmd_req_i & cmd_gnt_i & (cmd_sid_i == TRANS_SID_WIDTH'(s));
            comp[s]  = done_valid_i & (done_sid_i == TRANS_SID_WIDTH'(s));
        end
    end

    // Per-SID next-state, counter update and error detection
    always_comb begin
        term_d  = '0;
        busy_d  = '0;
        err_vec = '0;
        for (int s = 0; s < NB_TRANSFERS; s++) begin
            state_d[s] = state_q[s];
            cnt_d[s]   = cnt_q[s];

            unique case (state_q[s])
                S_IDLE, S_ACTIVE: begin
                    // Simultaneous issue and completion cancel out
                    if (issue[s] && !comp[s]) begin
                        if (cnt_q[s] == CNT_MAX) err_vec[s] = 1'b1;
                        else                     cnt_d[s]   = cnt_q[s] + CNT_ONE;
                    end else if (comp[s] && !issue[s]) begin
                        if (cnt_q[s] == CNT_ZERO) err_vec[s] = 1'b1;
                        else                      cnt_d[s]   = cnt_q[s] - CNT_ONE;
                    end
                    if (issue[s]) begin
                        state_d[s] = cmd_last_i ? S_DRAIN : S_ACTIVE;
                    end
                end
                S_DRAIN: begin
                    // No further issues are legal once the last chunk went out
                    if (issue[s]) err_vec[s] = 1'b1;
                    if (comp[s]) begin
                        if (cnt_q[s] == CNT_ZERO) err_vec[s] = 1'b1;
                        else                      cnt_d[s]   = cnt_q[s] - CNT_ONE;
                    end
                    if (cnt_d[s] == CNT_ZERO) state_d[s] = S_TERM;
                end
                S_TERM: begin
                    if (issue[s] || comp[s]) err_vec[s] = 1'b1;
                    state_d[s] = S_IDLE;
                end
                default: state_d[s] = S_IDLE;
            endcase

            term_d[s] = (state_d[s] == S_TERM);
            busy_d[s] = (state_d[s] != S_IDLE);
        end
        err_d = err_q | (|err_vec);
    end

    // State, counter and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < NB_TRANSFERS; s++) begin
                state_q[s] <= S_IDLE;
                cnt_q[s]   <= CNT_ZERO;
            end
            term_q <= '0;
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int s = 0; s < NB_TRANSFERS; s++) begin
                state_q[s] <= state_d[s];
                cnt_q[s]   <= cnt_d[s];
            end
            term_q <= term_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    // Counter-full flags decoded straight from the counter registers
    always_comb begin
        cnt_full_o = '0;
        for (int s = 0; s < NB_TRANSFERS; s++) begin
            cnt_full_o[s] = (cnt_q[s] == CNT_MAX);
        end
    end

    assign term_sig_o = term_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_trans_term_tracker.sv
`timescale 1ns/1ps
// Testbench for trans_term_tracker (CNT_WIDTH=2, so max outstanding is 3).
// Expected term pulses (cycle + vector) are queued by the stimulus; a monitor
// pops and compares whenever term_sig_o is non-zero.
module tb_trans_term_tracker;

    logic       clk;
    logic       rst_n;
    logic       cmd_req, cmd_gnt, cmd_last, done_valid;
    logic [1:0] cmd_sid, done_sid;
    logic [3:0] term_sig, cnt_full, busy;
    logic       err;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passed = 0;
    bit   mon_en = 1'b0;

    trans_term_tracker #(
        .NB_TRANSFERS   (4),
        .TRANS_SID_WIDTH(2),
        .CNT_WIDTH      (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_req_i   (cmd_req),
        .cmd_gnt_i   (cmd_gnt),
        .cmd_sid_i   (cmd_sid),
        .cmd_last_i  (cmd_last),
        .done_valid_i(done_valid),
        .done_sid_i  (done_sid),
        .term_sig_o  (term_sig),
        .cnt_full_o  (cnt_full),
        .err_o       (err),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every non-zero term_sig must match the head of the queue
    always @(negedge clk) begin
        if (mon_en && term_sig !== 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_term: cycle %0d got %b, none expected", cyc, term_sig);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc == cyc && e.vec === term_sig) passed++;
                else $display("FAIL term_pulse: got %b at cycle %0d, expected %b at cycle %0d",
                              term_sig, cyc, e.vec, e.cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, expv);
    endtask

    // One clock of stimulus; inputs return to idle #1 after the sampling edge
    task automatic tick(input logic req, input logic gnt, input logic [1:0] sid,
                        input logic last, input logic dv, input logic [1:0] dsid);
        cmd_req    = req;
        cmd_gnt    = gnt;
        cmd_sid    = sid;
        cmd_last   = last;
        done_valid = dv;
        done_sid   = dsid;
        @(posedge clk);
        #1;
        cmd_req    = 1'b0;
        cmd_gnt    = 1'b0;
        cmd_sid    = 2'd0;
        cmd_last   = 1'b0;
        done_valid = 1'b0;
        done_sid   = 2'd0;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic issue(input logic [1:0] sid, input logic last);
        tick(1'b1, 1'b1, sid, last, 1'b0, 2'd0);
    endtask

    task automatic done(input logic [1:0] sid);
        tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, sid);
    endtask

    // Pulse is due in the cycle following the edge just taken
    task automatic expect_term(input logic [3:0] v);
        exp_q.push_back('{cyc, v});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_req = 1'b0; cmd_gnt = 1'b0; cmd_sid = 2'd0; cmd_last = 1'b0;
        done_valid = 1'b0; done_sid = 2'd0;
        idle();
        idle();
        rst_n = 1'b1;
        mon_en = 1'b1;
        chk("reset_term", term_sig, 4'b0000);
        chk("reset_full", cnt_full, 4'b0000);
        chk("reset_err", {3'b000, err}, 4'b0000);
        chk("reset_busy", busy, 4'b0000);

        // Request without grant issues nothing
        tick(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 2'd0);
        chk("no_gnt_busy", busy, 4'b0000);

        // Single-chunk transfer on sid 2
        issue(2'd2, 1'b1);
        chk("single_busy", busy, 4'b0100);
        idle();
        done(2'd2);
        expect_term(4'b0100);
        idle();
        chk("single_busy_after", busy, 4'b0000);
        chk("single_err", {3'b000, err}, 4'b0000);

        // Multi-chunk on sid 1 with interleaved completion
        issue(2'd1, 1'b0);
        issue(2'd1, 1'b0);
        done(2'd1);
        issue(2'd1, 1'b1);
        done(2'd1);
        chk("multi_busy_mid", busy, 4'b0010);
        idle();
        done(2'd1);
        expect_term(4'b0010);
        idle();
        chk("multi_err", {3'b000, err}, 4'b0000);
        chk("multi_busy_after", busy, 4'b0000);

        // sid 0 count 1: last issue plus completion in one cycle keeps count 1
        issue(2'd0, 1'b0);
        tick(1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 2'd0);
        idle();
        chk("simul_still_busy", busy, 4'b0001);
        done(2'd0);
        expect_term(4'b0001);
        idle();
        chk("simul_busy_after", busy, 4'b0000);
        chk("simul_err", {3'b000, err}, 4'b0000);

        // sid 0 and sid 3 both reach TERM on the same edge
        issue(2'd3, 1'b0);
        done(2'd3);                               // sid 3 ACTIVE, count 0
        issue(2'd0, 1'b1);                        // sid 0 DRAIN, count 1
        tick(1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 2'd3); // sid 3 DRAIN, count 0
        chk("dual_busy", busy, 4'b1001);
        done(2'd0);
        expect_term(4'b1001);
        idle();
        chk("dual_busy_after", busy, 4'b0000);

        // Overflow / underflow
        do_reset();
        issue(2'd0, 1'b0);
        issue(2'd0, 1'b0);
        chk("ovf_not_full", cnt_full, 4'b0000);
        issue(2'd0, 1'b0);
        chk("ovf_full", cnt_full, 4'b0001);
        chk("ovf_err_before", {3'b000, err}, 4'b0000);
        issue(2'd0, 1'b0);
        chk("ovf_err", {3'b000, err}, 4'b0001);
        chk("ovf_still_full", cnt_full, 4'b0001);
        done(2'd1);
        chk("unf_err_sticky", {3'b000, err}, 4'b0001);
        chk("unf_sid1_idle", busy, 4'b0001);
        done(2'd0);
        chk("ovf_dec", cnt_full, 4'b0000);

        // Reset mid-transfer: sid 1 in DRAIN with count 2
        do_reset();
        issue(2'd1, 1'b0);
        issue(2'd1, 1'b1);
        chk("mid_busy", busy, 4'b0010);
        do_reset();
        chk("mid_rst_term", term_sig, 4'b0000);
        chk("mid_rst_busy", busy, 4'b0000);
        chk("mid_rst_err", {3'b000, err}, 4'b0000);
        chk("mid_rst_full", cnt_full, 4'b0000);
        done(2'd1);
        chk("mid_done_err", {3'b000, err}, 4'b0001);
        chk("mid_done_busy", busy, 4'b0000);
        idle();

        // Back-to-back reuse of sid 2 right after its pulse
        do_reset();
        issue(2'd2, 1'b1);
        done(2'd2);
        expect_term(4'b0100);
        idle();
        issue(2'd2, 1'b1);
        chk("reuse_busy", busy, 4'b0100);
        chk("reuse_err", {3'b000, err}, 4'b0000);
        done(2'd2);
        expect_term(4'b0100);
        idle();
        idle();
        chk("reuse_err_end", {3'b000, err}, 4'b0000);
        chk("reuse_busy_end", busy, 4'b0000);

        idle();
        idle();
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL missing_term: %0d expected pulse(s) never seen, want 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
